hit_timestamper: RTL and testbench

HIT_TIMESTAMPER -- requirements
Module: hit_timestamper

---
 rtl/hit_timestamper.sv | 119 +++++++++++
 tb/tb_hit_timestamper.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_timestamper.sv
// Timestamps rising edges of a hit level against a free-running Gray counter,
// extends the count with a wrap epoch and queues {epoch, binary} in a small FIFO.
module hit_timestamper #(
    parameter int P_WIDTH       = 4,
    parameter int P_EPOCH_WIDTH = 4,
    parameter int P_DEPTH       = 4
) (
    input  logic                             clk_i,
    input  logic                             init_i,
    input  logic [P_WIDTH-1:0]               gray_count_i,
    input  logic                             hit_i,
    input  logic                             ts_ready_i,
    output logic [P_EPOCH_WIDTH+P_WIDTH-1:0] ts_data_o,
    output logic                             ts_valid_o,
    output logic                             overflow_o,
    output logic [7:0]                       drop_count_o
);

    localparam int DW = P_EPOCH_WIDTH + P_WIDTH;
    localparam int AW = $clog2(P_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [P_WIDTH-1:0]       cnt_q;
    logic [P_WIDTH-1:0]       bin_q;
    logic [P_WIDTH-1:0]       bin_d;
    logic                     hit_q;
    logic                     hit_dly_q;
    logic [P_EPOCH_WIDTH-1:0] epoch_q;
    logic [P_EPOCH_WIDTH-1:0] epoch_d;
    logic [AW:0]              wr_ptr_q;
    logic [AW:0]              wr_ptr_d;
    logic [AW:0]              wr_vis_q;
    logic [AW:0]              rd_ptr_q;
    logic [AW:0]              rd_ptr_d;
    logic                     overflow_q;
    logic                     overflow_d;
    logic [7:0]               drop_q;
    logic [7:0]               drop_d;
    logic [DW-1:0]            mem_q [P_DEPTH];
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     accept;

    always_comb begin
        bin_d = '0;
        bin_d[P_WIDTH-1] = cnt_q[P_WIDTH-1];
        for (int i = P_WIDTH - 2; i >= 0; i--) begin
            bin_d[i] = bin_d[i+1] ^ cnt_q[i];
        end
    end

    // bin_q is the previous conversion; any decrease means the counter wrapped
    assign epoch_d = (bin_d < bin_q) ? epoch_q + P_EPOCH_WIDTH'(1) : epoch_q;

    assign push   = hit_q & ~hit_dly_q;
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Reads see the write pointer one edge late, so a fresh entry appears the edge after its write
    assign ts_valid_o = (rd_ptr_q != wr_vis_q);
    assign pop        = ts_valid_o & ts_ready_i;
    assign accept     = push & (~full | pop);
    assign ts_data_o  = ts_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !accept) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // hit history resets high so a level already high at release is not an edge
    always_ff @(posedge clk_i or posedge init_i) begin
        if (init_i) begin
            cnt_q      <= '0;
            bin_q      <= '0;
            hit_q      <= 1'b1;
            hit_dly_q  <= 1'b1;
            epoch_q    <= '0;
            wr_ptr_q   <= '0;
            wr_vis_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            cnt_q      <= gray_count_i;
            bin_q      <= bin_d;
            hit_q      <= hit_i;
            hit_dly_q  <= hit_q;
            epoch_q    <= epoch_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_vis_q   <= wr_ptr_q;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {epoch_d, bin_d};
        end
    end

endmodule

// File: tb/tb_hit_timestamper.sv
// Self-checking bench for hit_timestamper: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_hit_timestamper;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       init = 1'b0;
    logic [3:0] gray = '0;
    logic       hit = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] ts_data;
    logic       ts_valid;
    logic       overflow;
    logic [7:0] drop_count;

    logic [3:0] bcnt = '0;
    logic [3:0] bin_drv = '0;
    bit         chk_en = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    hit_timestamper dut (
        .clk_i        (clk),
        .init_i       (init),
        .gray_count_i (gray),
        .hit_i        (hit),
        .ts_ready_i   (ready),
        .ts_data_o    (ts_data),
        .ts_valid_o   (ts_valid),
        .overflow_o   (overflow),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: entries carry the binary sampled with the hit and the
    // number of counter decreases seen so far; an entry is written one edge after
    // its hit is sampled and becomes readable one edge after that.
    logic [7:0] fifo_m[$];
    int         nvis_m;
    bit         prev_h_m;
    logic [3:0] last_b_m;
    logic [3:0] ep_m;
    bit         pend_m;
    logic [7:0] pend_d_m;
    bit         ovf_m;
    int         drops_m;

    always @(posedge clk or posedge init) begin
        int nv;
        if (init) begin
            fifo_m.delete();
            nvis_m   = 0;
            prev_h_m = 1'b1;
            last_b_m = '0;
            ep_m     = '0;
            pend_m   = 1'b0;
            pend_d_m = '0;
            ovf_m    = 1'b0;
            drops_m  = 0;
        end else begin
            if (nvis_m > 0 && ready) begin
                void'(fifo_m.pop_front());
                nvis_m--;
            end
            nv = fifo_m.size();
            if (pend_m) begin
                if (fifo_m.size() < DEPTH) begin
                    fifo_m.push_back(pend_d_m);
                end else begin
                    ovf_m = 1'b1;
                    if (drops_m < 255) drops_m++;
                end
            end
            nvis_m = nv;
            if (bin_drv < last_b_m) ep_m = ep_m + 4'd1;
            last_b_m = bin_drv;
            pend_m   = hit && !prev_h_m;
            pend_d_m = {ep_m, bin_drv};
            prev_h_m = hit;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", {31'd0, ts_valid}, {31'd0, (nvis_m > 0)});
            chk("model_data", {24'd0, ts_data}, {24'd0, (nvis_m > 0) ? fifo_m[0] : 8'h00});
            chk("model_overflow", {31'd0, overflow}, {31'd0, ovf_m});
            chk("model_drops", {24'd0, drop_count}, drops_m);
        end
    end

    // One clock: drive inputs, cross the rising edge, settle 1 time unit after it.
    task automatic tick(input bit h, input bit r);
        hit     = h;
        ready   = r;
        bin_drv = bcnt;
        gray    = bcnt ^ (bcnt >> 1);
        @(posedge clk);
        #1;
        bcnt = bcnt + 4'd1;
    endtask

    task automatic apply_init(input bit h);
        hit   = h;
        ready = 1'b0;
        init  = 1'b1;
        #1;
        chk("init_valid", {31'd0, ts_valid}, 32'd0);
        chk("init_data", {24'd0, ts_data}, 32'd0);
        chk("init_overflow", {31'd0, overflow}, 32'd0);
        chk("init_drops", {24'd0, drop_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        init = 1'b0;
        bcnt = '0;
    endtask

    task automatic pulse(input bit r);
        tick(1'b1, r);
        tick(1'b0, r);
    endtask

    initial begin
        logic [7:0] exp_q[4];
        int         cnt;

        @(posedge clk);
        #1;
        apply_init(1'b0);
        chk_en = 1'b1;

        // Single hit at Gray 0110 (binary 4)
        repeat (4) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("lat_edge_n", {31'd0, ts_valid}, 32'd0);
        tick(1'b0, 1'b0);
        chk("lat_edge_n1", {31'd0, ts_valid}, 32'd0);
        tick(1'b0, 1'b0);
        chk("lat_edge_n2", {31'd0, ts_valid}, 32'd1);
        chk("lat_data", {24'd0, ts_data}, 32'h04);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("lat_drained", {31'd0, ts_valid}, 32'd0);

        // Two full counter wraps, then hit at Gray 0001
        apply_init(1'b0);
        repeat (33) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("epoch_valid", {31'd0, ts_valid}, 32'd1);
        chk("epoch_data", {24'd0, ts_data}, 32'h21);

        // Overflow: six pulses into a stalled four-deep FIFO
        apply_init(1'b0);
        tick(1'b0, 1'b0);
        repeat (6) pulse(1'b0);
        repeat (2) tick(1'b0, 1'b0);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_drops", {24'd0, drop_count}, 32'd2);
        exp_q = '{8'h01, 8'h03, 8'h05, 8'h07};
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_valid", {31'd0, ts_valid}, 32'd1);
            chk("ovf_drain_data", {24'd0, ts_data}, {24'd0, exp_q[i]});
            tick(1'b0, 1'b1);
        end
        chk("ovf_empty", {31'd0, ts_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full FIFO: push and pop land on the same edge
        apply_init(1'b0);
        tick(1'b0, 1'b0);
        repeat (4) pulse(1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("same_edge_drops", {24'd0, drop_count}, 32'd0);
        chk("same_edge_ovf", {31'd0, overflow}, 32'd0);
        exp_q = '{8'h03, 8'h05, 8'h07, 8'h09};
        for (int i = 0; i < 4; i++) begin
            chk("same_edge_data", {24'd0, ts_data}, {24'd0, exp_q[i]});
            tick(1'b0, 1'b1);
        end
        chk("same_edge_empty", {31'd0, ts_valid}, 32'd0);

        // Long hit gives one entry
        apply_init(1'b0);
        tick(1'b0, 1'b0);
        repeat (10) tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (ts_valid) cnt++;
            tick(1'b0, 1'b1);
        end
        chk("long_hit_entries", cnt, 32'd1);

        // Hit held high across release gives nothing
        apply_init(1'b1);
        repeat (5) tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        chk("hit_across_init", {31'd0, ts_valid}, 32'd0);

        // Init mid-operation with stored entries, nonzero epoch and overflow
        apply_init(1'b0);
        repeat (20) tick(1'b0, 1'b0);
        repeat (6) pulse(1'b0);
        tick(1'b0, 1'b0);
        chk("pre_init_valid", {31'd0, ts_valid}, 32'd1);
        chk("pre_init_ovf", {31'd0, overflow}, 32'd1);
        pulse(1'b0);
        apply_init(1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("post_init_empty", {31'd0, ts_valid}, 32'd0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("post_init_data", {24'd0, ts_data}, 32'h02);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("post_init_stale", {31'd0, ts_valid}, 32'd0);

        // Randomized traffic against the model
        apply_init(1'b0);
        for (int i = 0; i < 3000; i++) begin
            bit h;
            bit r;
            if ($urandom_range(0, 15) == 0) bcnt = 4'($urandom_range(0, 15));
            h = ($urandom_range(0, 2) == 0) ? ~hit : hit;
            r = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : ready;
            if ($urandom_range(0, 499) == 0) begin
                apply_init(h);
            end else begin
                tick(h, r);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
